vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameter H_FP, 16, horizontal front porch (pixels).
REQ-003 Parameter H_SYNC, 96, horizontal sync width (pixels).
REQ-004 Parameter H_BP, 48, horizontal back porch (pixels).
REQ-005 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-006 Parameter V_FP, 10, vertical front porch (lines).
REQ-007 Parameter V_SYNC, 2, vertical sync width (lines).
REQ-008 Parameter V_BP, 33, vertical back porch (lines).
REQ-009 Parameter HS_POL, 0, hsync active level; 0 means active-low.
REQ-010 Parameter VS_POL, 0, vsync active level; 0 means active-low.
REQ-011 Parameter PIX_DIV, 1, clk cycles per pixel; legal range 1..8.
REQ-012 Parameter FRAME_W, 8, frame counter width.
REQ-013 Derived: H_TOTAL and V_TOTAL are the sums of their four terms; HW = clog2(H_TOTAL); VW = clog2(V_TOTAL).
REQ-014 Port clk, input, 1, system clock; the block uses this single clock.
REQ-015 Port rst_n, input, 1, asynchronous active-low reset.
REQ-016 Port ena, input, 1, run enable; low freezes all timing state.
REQ-017 Port hpos, output, HW, current pixel column.
REQ-018 Port vpos, output, VW, current line.
REQ-019 Port hsync, output, 1, horizontal sync at HS_POL level when active.
REQ-020 Port vsync, output, 1, vertical sync at VS_POL level when active.
REQ-021 Port display_on, output, 1, high inside the visible area.
REQ-022 Port line_start, output, 1, one-clk pulse at the start of each line.
REQ-023 Port frame_start, output, 1, one-clk pulse at the start of each frame.
REQ-024 Port frame_cnt, output, FRAME_W, count of completed frames.

Function
REQ-025 A divider count runs 0..PIX_DIV-1; a pixel tick occurs when running, ena=1 and the divider count = PIX_DIV-1.
REQ-026 On each tick, hpos increments; at H_TOTAL-1 it wraps to 0 and vpos increments.
REQ-027 When hpos and vpos both wrap, vpos becomes 0 and frame_cnt increments modulo 2^FRAME_W.
REQ-028 An internal running flag clears on reset and sets on the first clk edge with rst_n high; no counter advances on that edge.
REQ-029 display_on = running AND hpos < H_ACTIVE AND vpos < V_ACTIVE.
REQ-030 hsync is active when running and hpos is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; otherwise it is inactive.
REQ-031 vsync is active when running and vpos is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], for the whole line; otherwise it is inactive.
REQ-032 line_start = running AND ena AND hpos=0 AND divider count=0; the pulse is exactly one clk wide for any PIX_DIV.
REQ-033 frame_start = line_start AND vpos=0.
REQ-034 Outputs decode combinationally from registered state, with zero latency relative to hpos/vpos.
REQ-035 When ena=0, the divider, hpos, vpos and frame_cnt hold; line_start and frame_start are 0; sync and display_on reflect the held position.
REQ-036 Elaboration fails if PIX_DIV is outside 1..8, or if any porch, sync or active parameter is 0.

Reset
REQ-037 While rst_n=0: divider, hpos, vpos and frame_cnt are 0; running is 0; hsync=~HS_POL; vsync=~VS_POL; display_on, line_start and frame_start are 0.
REQ-038 Reset takes effect asynchronously at any point in a frame; timing after release is identical to timing after power-up.

Structure
REQ-039 Shared package vga_pkg holds the default 640x480@60 timing constants and a width helper; the module imports it.
REQ-040 Sub-module wrap_counter (parameters MAX and W; ports inc, wrap) is instantiated once for the horizontal axis and once for the vertical axis.

Verification
REQ-041 Test parameters unless stated: H 8/2/3/1 (H_TOTAL 14), V 4/1/2/1 (V_TOTAL 8), PIX_DIV 1, FRAME_W 2.
REQ-042 Reset: hold rst_n low 5 cycles -> hpos=0, vpos=0, hsync=1, vsync=1, display_on=0, no pulses.
REQ-043 Line timing: release reset -> line_start every 14 cycles; hsync low only for hpos 10..12 (3 cycles); display_on high for hpos 0..7 while vpos<4.
REQ-044 Frame timing: frame_start every 112 cycles; vsync low for vpos 5..6 (28 cycles); frame_cnt steps 0,1,2,3,0 across 5 frames.
REQ-045 PIX_DIV=3: line period 42 cycles; each hpos value held 3 cycles; line_start is 1 cycle wide.
REQ-046 Pause and reset: drop ena for 10 cycles at hpos=5 -> hpos stays 5 with no pulses, then advances to 6 on the first tick after ena rises; assert rst_n at vpos=6 -> outputs take reset values immediately, and restart timing matches REQ-043.

Source files
------------

// File: rtl/vga_pkg.sv
// Default 640x480@60 raster constants and a counter-width helper.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  // Bits needed to hold 0..n-1; never less than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-MAX counter advancing on inc; wrap flags the inc that returns it to 0.
// Latency: count updates one clk after inc, wrap is combinational; no backpressure.
module wrap_counter #(
  parameter int MAX = 2,
  parameter int W   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         wrap
);

  assign wrap = inc && (count == W'(MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc) begin
      count <= wrap ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel divider, h/v position counters, sync/blank decode.
// Latency: decoded outputs are zero-latency from hpos/vpos; ena low stalls all timing state.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIX_DIV  = 1,
  parameter int FRAME_W  = 8,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = cnt_w(H_TOTAL),
  localparam int VW      = cnt_w(V_TOTAL)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  output logic [HW-1:0]      hpos,
  output logic [VW-1:0]      vpos,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int DW = cnt_w(PIX_DIV);

  localparam logic [HW-1:0] H_ACT_L  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG_L = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END_L = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_ACT_L  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG_L = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END_L = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [DW-1:0] DIV_MAX_L = DW'(PIX_DIV - 1);

  if (PIX_DIV < 1 || PIX_DIV > 8) begin : g_bad_div
    $error("vga_timing_gen: PIX_DIV must be within 1..8");
  end
  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_timing
    $error("vga_timing_gen: active, porch and sync parameters must be non-zero");
  end

  logic          running;
  logic [DW-1:0] div_cnt;
  logic          adv;
  logic          tick;
  logic          h_wrap;
  logic          v_wrap;

  assign adv  = running && ena;
  assign tick = adv && (div_cnt == DIV_MAX_L);

  // running keeps the first edge after reset release from advancing anything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running   <= 1'b0;
      div_cnt   <= '0;
      frame_cnt <= '0;
    end else begin
      running <= 1'b1;
      if (adv) begin
        div_cnt <= tick ? '0 : div_cnt + DW'(1);
      end
      if (v_wrap) begin
        frame_cnt <= frame_cnt + FRAME_W'(1);
      end
    end
  end

  wrap_counter #(.MAX(H_TOTAL), .W(HW)) u_hcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (tick),
    .count (hpos),
    .wrap  (h_wrap)
  );

  wrap_counter #(.MAX(V_TOTAL), .W(VW)) u_vcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (h_wrap),
    .count (vpos),
    .wrap  (v_wrap)
  );

  assign display_on  = running && (hpos < H_ACT_L) && (vpos < V_ACT_L);
  assign hsync       = (running && hpos >= HS_BEG_L && hpos <= HS_END_L) ? HS_POL : ~HS_POL;
  assign vsync       = (running && vpos >= VS_BEG_L && vpos <= VS_END_L) ? VS_POL : ~VS_POL;
  // Qualifying on div_cnt==0 keeps the pulse one clk wide when a pixel spans several clks.
  assign line_start  = adv && (hpos == '0) && (div_cnt == '0);
  assign frame_start = line_start && (vpos == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: small 14x8 raster at PIX_DIV 1 and 3, reset/pause behaviour.
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  logic       rst_n, ena, rst3_n, ena3;

  logic [3:0] hpos, hpos3;
  logic [2:0] vpos, vpos3;
  logic       hsync, vsync, display_on, line_start, frame_start;
  logic       hsync3, vsync3, display_on3, line_start3, frame_start3;
  logic [1:0] frame_cnt, frame_cnt3;

  int vectors = 0;
  int miscompares = 0;
  int hs_low = 0;
  int vs_low = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIX_DIV(1), .FRAME_W(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .hpos(hpos), .vpos(vpos), .hsync(hsync), .vsync(vsync),
    .display_on(display_on), .line_start(line_start),
    .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIX_DIV(3), .FRAME_W(2)
  ) dut3 (
    .clk(clk), .rst_n(rst3_n), .ena(ena3),
    .hpos(hpos3), .vpos(vpos3), .hsync(hsync3), .vsync(vsync3),
    .display_on(display_on3), .line_start(line_start3),
    .frame_start(frame_start3), .frame_cnt(frame_cnt3)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs n cycles after the first running edge, PIX_DIV=1.
  task automatic check_pos(input int n);
    int h, v, f;
    h = n % 14;
    v = (n / 14) % 8;
    f = (n / 112) % 4;
    chk("hpos", int'(hpos), h);
    chk("vpos", int'(vpos), v);
    chk("frame_cnt", int'(frame_cnt), f);
    chk("hsync", int'(hsync), (h >= 10 && h <= 12) ? 0 : 1);
    chk("vsync", int'(vsync), (v >= 5 && v <= 6) ? 0 : 1);
    chk("display_on", int'(display_on), (h < 8 && v < 4) ? 1 : 0);
    chk("line_start", int'(line_start), (h == 0) ? 1 : 0);
    chk("frame_start", int'(frame_start), (h == 0 && v == 0) ? 1 : 0);
    if (!hsync) hs_low++;
    if (!vsync) vs_low++;
  endtask

  task automatic run_cycles(input int count);
    for (int i = 0; i < count; i++) begin
      check_pos(i);
      step();
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_hpos"}, int'(hpos), 0);
    chk({tag, "_vpos"}, int'(vpos), 0);
    chk({tag, "_frame_cnt"}, int'(frame_cnt), 0);
    chk({tag, "_hsync"}, int'(hsync), 1);
    chk({tag, "_vsync"}, int'(vsync), 1);
    chk({tag, "_display_on"}, int'(display_on), 0);
    chk({tag, "_line_start"}, int'(line_start), 0);
    chk({tag, "_frame_start"}, int'(frame_start), 0);
  endtask

  initial begin
    int guard;
    rst_n = 1'b0; ena = 1'b1; rst3_n = 1'b0; ena3 = 1'b1;

    repeat (5) @(posedge clk);
    #1;
    check_reset_vals("rst");

    // Release: the next edge only sets running, so hpos stays 0 and pulses appear.
    rst_n = 1'b1;
    step();
    hs_low = 0;
    vs_low = 0;
    run_cycles(560);
    chk("hsync_low_cycles_5frames", hs_low, 5 * 8 * 3);
    chk("vsync_low_cycles_5frames", vs_low, 5 * 28);

    // Pause at hpos=5 for 10 cycles.
    repeat (5) step();
    chk("pre_pause_hpos", int'(hpos), 5);
    ena = 1'b0;
    #1;
    chk("pause_line_start", int'(line_start), 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("pause_hpos", int'(hpos), 5);
      chk("pause_vpos", int'(vpos), 0);
      chk("pause_line_start", int'(line_start), 0);
      chk("pause_frame_start", int'(frame_start), 0);
      chk("pause_display_on", int'(display_on), 1);
    end
    ena = 1'b1;
    step();
    chk("resume_hpos", int'(hpos), 6);

    // Asynchronous reset in the middle of the vsync region.
    guard = 0;
    while (vpos != 3'd6 && guard < 200) begin
      step();
      guard++;
    end
    chk("reach_vpos6", int'(vpos), 6);
    repeat (3) step();
    chk("pre_reset_vsync", int'(vsync), 0);
    chk("pre_reset_hpos", int'(hpos), 3);
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    repeat (2) step();
    check_reset_vals("async_rst_hold");
    rst_n = 1'b1;
    step();
    run_cycles(112);

    // PIX_DIV=3 instance: 3 clks per pixel, 42-clk lines, 1-clk line_start.
    rst3_n = 1'b1;
    step();
    for (int n = 0; n < 84; n++) begin
      chk("div3_hpos", int'(hpos3), (n / 3) % 14);
      chk("div3_vpos", int'(vpos3), (n / 42) % 8);
      chk("div3_line_start", int'(line_start3), (n % 42 == 0) ? 1 : 0);
      chk("div3_frame_start", int'(frame_start3), (n == 0) ? 1 : 0);
      chk("div3_hsync", int'(hsync3), ((n % 42) >= 30 && (n % 42) <= 38) ? 0 : 1);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
